// File: rtl/mac_acc.sv
// mac_acc: multi-lane integer multiply-accumulate with vector framing.
// Stage 1 registers lane products, stage 2 accumulates and publishes.
module mac_acc #(
  parameter int LANES = 2,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [16*LANES-1:0]      value,
  input  logic [16*LANES-1:0]      weight,
  input  logic [24*LANES-1:0]      bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W*LANES-1:0]   result,
  output logic [LANES-1:0]         out_sat,
  output logic                     out_err,
  output logic [CNT_W-1:0]         out_cnt
);

  localparam int PROD_W = 32;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 2;

  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(ACC_MAX);
  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(ACC_MIN);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  function automatic logic is_legal(input logic [3:0] m);
    return (m == 4'b0010) || (m == 4'b0100) || (m == 4'b1000);
  endfunction

  // sel is either all-zero or a legal one-hot mode
  function automatic logic signed [PROD_W-1:0] lane_prod(
    input logic [15:0] v,
    input logic [15:0] w,
    input logic [3:0]  sel
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    logic signed [PROD_W-1:0] p;
    a = '0;
    b = '0;
    p = '0;
    unique case (1'b1)
      sel[1]: begin
        for (int i = 0; i < 4; i++) begin
          a = PROD_W'(signed'(v[i*4 +: 4]));
          b = PROD_W'(signed'(w[i*4 +: 4]));
          p = p + a * b;
        end
      end
      sel[2]: begin
        for (int i = 0; i < 2; i++) begin
          a = PROD_W'(signed'(v[i*8 +: 8]));
          b = PROD_W'(signed'(w[i*8 +: 8]));
          p = p + a * b;
        end
      end
      sel[3]: begin
        a = PROD_W'(signed'(v));
        b = PROD_W'(signed'(w));
        p = a * b;
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       mode_q, mode_d;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;
  logic             s1_err_q, s1_err_d;

  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             en;
  logic             take;
  logic             first_c;
  logic             in_legal;
  logic             beat_err;
  logic [3:0]       eff_mode;
  logic [3:0]       sel_mode;
  logic             step;
  logic             done;

  // Handshake and per-beat mode resolution at the input
  always_comb begin
    en       = !(out_valid_q && !out_ready);
    take     = in_valid && en;
    first_c  = (state_q == IDLE);
    in_legal = is_legal(mode);
    eff_mode = first_c ? mode : mode_q;
    sel_mode = (in_legal && is_legal(eff_mode)) ? eff_mode : 4'b0000;
    beat_err = !in_legal || (!first_c && (mode != mode_q));
    step     = en && s1_valid_q;
    done     = step && s1_last_q;
  end

  // Vector framing FSM and mode latch
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (take) begin
      if (first_c) begin
        mode_d = mode;
      end
      state_d = in_last ? IDLE : ACC;
    end
  end

  // Stage 1 control bundle
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_err_d   = s1_err_q;
    if (en) begin
      s1_valid_d = take;
      s1_first_d = first_c;
      s1_last_d  = in_last;
      s1_err_d   = beat_err;
    end
  end

  // Stage 2 vector error/count tracking and output handshake
  always_comb begin
    err_d       = err_q;
    cnt_d       = cnt_q;
    out_err_d   = out_err_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    if (step) begin
      if (s1_first_q) begin
        err_d = s1_err_q;
        cnt_d = CNT_W'(1);
      end else begin
        err_d = err_q || s1_err_q;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end
    end
    if (done) begin
      out_err_d   = err_d;
      out_cnt_d   = cnt_d;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Shared control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_err_q    <= s1_err_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [23:0]       bias_q, bias_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  res_q, res_d;
    logic                     sat_q, sat_d;
    logic                     osat_q, osat_d;
    logic signed [SUM_W-1:0]  base;
    logic signed [SUM_W-1:0]  sum;
    logic                     ovf_hi;
    logic                     ovf_lo;

    assign prod_c = lane_prod(value[g*16 +: 16],
                              weight[g*16 +: 16],
                              sel_mode);

    // Stage 1: capture product and bias of an accepted beat
    always_comb begin
      prod_d = prod_q;
      bias_d = bias_q;
      if (take) begin
        prod_d = prod_c;
        bias_d = bias[g*24 +: 24];
      end
    end

    // Stage 2: full-precision add, clamp to ACC_W, sticky sat
    always_comb begin
      base   = s1_first_q ? SUM_W'(bias_q) : SUM_W'(acc_q);
      sum    = base + SUM_W'(prod_q);
      ovf_hi = sum > MAX_S;
      ovf_lo = sum < MIN_S;
      acc_d  = acc_q;
      sat_d  = sat_q;
      res_d  = res_q;
      osat_d = osat_q;
      if (step) begin
        if (ovf_hi) begin
          acc_d = ACC_MAX;
        end else if (ovf_lo) begin
          acc_d = ACC_MIN;
        end else begin
          acc_d = ACC_W'(sum);
        end
        sat_d = (!s1_first_q && sat_q) || ovf_hi || ovf_lo;
        if (s1_last_q) begin
          res_d  = acc_d;
          osat_d = sat_d;
        end
      end
    end

    // Lane datapath registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
        bias_q <= '0;
        acc_q  <= '0;
        sat_q  <= 1'b0;
        res_q  <= '0;
        osat_q <= 1'b0;
      end else begin
        prod_q <= prod_d;
        bias_q <= bias_d;
        acc_q  <= acc_d;
        sat_q  <= sat_d;
        res_q  <= res_d;
        osat_q <= osat_d;
      end
    end

    assign result[g*ACC_W +: ACC_W] = res_q;
    assign out_sat[g]               = osat_q;
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_cnt   = out_cnt_q;

endmodule
